// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive path: state encodings,
// default bus width and error-counter width.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam int GRAY_WIDTH = 3;
    localparam int ERRCNT_W   = 8;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // A reduction per bit avoids a self-referencing vector chain.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_decoder.sv
// Gray-count receiver: decodes sampled words, classifies steps, flags wrap and
// faults, resynchronises after faults. Macro GRAY_ERRCNT_EN enables ErrCount.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH,
    parameter int RESYNC = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                En,
    input  logic [WIDTH-1:0]    GrayIn,
    output logic [WIDTH-1:0]    Binary,
    output logic                Valid,
    output logic                Step,
    output logic                Dir,
    output logic                Overflow,
    output logic                Underflow,
    output logic                Error,
    output logic [ERRCNT_W-1:0] ErrCount
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [3:0]       RESYNC_C = 4'(RESYNC);

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] diff;
    logic             is_up;
    logic             is_down;
    logic             is_hold;
    logic             is_legal;

    state_e           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] binary_q;
    logic             valid_q;
    logic             step_q;
    logic             dir_q;
    logic             ovf_q;
    logic             unf_q;
    logic [3:0]       resync_q;
    logic [3:0]       resync_d;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray_i (GrayIn),
        .bin_o  (bin_new)
    );

    // Up wins over down so that WIDTH=1 (where +1 == -1) reads as up.
    assign diff     = bin_new - prev_q;
    assign is_up    = (diff == ONE);
    assign is_down  = !is_up && (diff == ALL_ONES);
    assign is_hold  = (diff == '0);
    assign is_legal = is_up || is_down || is_hold;
    assign resync_d = resync_q + 4'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            binary_q <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            resync_q <= '0;
        end else begin
            valid_q <= En;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            if (En) begin
                prev_q   <= bin_new;
                binary_q <= bin_new;
                case (state_q)
                    ST_IDLE: state_q <= ST_TRACK;
                    ST_TRACK: begin
                        if (is_legal) begin
                            step_q <= is_up || is_down;
                            if (is_up || is_down)
                                dir_q <= is_up;
                            ovf_q <= is_up && (prev_q == ALL_ONES);
                            unf_q <= is_down && (prev_q == '0);
                        end else begin
                            state_q  <= ST_FAULT;
                            resync_q <= '0;
                        end
                    end
                    ST_FAULT: begin
                        if (!is_legal) begin
                            resync_q <= '0;
                        end else if (resync_d == RESYNC_C) begin
                            state_q  <= ST_TRACK;
                            resync_q <= '0;
                        end else begin
                            resync_q <= resync_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign Binary    = binary_q;
    assign Valid     = valid_q;
    assign Step      = step_q;
    assign Dir       = dir_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Error     = (state_q == ST_FAULT);

`ifdef GRAY_ERRCNT_EN
    logic                illegal_evt;
    logic [ERRCNT_W-1:0] errcnt_q;
    logic [ERRCNT_W-1:0] errcnt_d;

    // IDLE only captures a reference, so it never contributes an error.
    assign illegal_evt = En && (state_q != ST_IDLE) && !is_legal;

    always_comb begin
        errcnt_d = errcnt_q;
        if (illegal_evt && (errcnt_q != '1))
            errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            errcnt_q <= '0;
        else
            errcnt_q <= errcnt_d;
    end

    assign ErrCount = errcnt_q;
`else
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder (WIDTH=3, RESYNC=2), checking each sample
// one time unit after the capturing edge.
module tb_gray_decoder;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic [2:0] GrayIn;
    logic [2:0] Binary;
    logic       Valid;
    logic       Step;
    logic       Dir;
    logic       Overflow;
    logic       Underflow;
    logic       Error;
    logic [7:0] ErrCount;

    int checks = 0;
    int errors = 0;

`ifdef GRAY_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    gray_decoder #(.WIDTH(3), .RESYNC(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .GrayIn    (GrayIn),
        .Binary    (Binary),
        .Valid     (Valid),
        .Step      (Step),
        .Dir       (Dir),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Error     (Error),
        .ErrCount  (ErrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] exp_cnt(input int n);
        if (!CNT_EN)
            return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [2:0] g);
        Reset  = rst;
        En     = en;
        GrayIn = g;
        @(posedge Clk);
        #1;
        $display("t=%0t rst=%0b en=%0b gray=%b -> bin=%0d v=%0b st=%0b dir=%0b ovf=%0b unf=%0b err=%0b cnt=%0d",
                 $time, rst, en, g, Binary, Valid, Step, Dir, Overflow, Underflow, Error, ErrCount);
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] bin, input logic v,
                             input logic st, input logic ovf, input logic unf, input logic err);
        chk({tag, ".bin"}, 32'(Binary), 32'(bin));
        chk({tag, ".valid"}, 32'(Valid), 32'(v));
        chk({tag, ".step"}, 32'(Step), 32'(st));
        chk({tag, ".ovf"}, 32'(Overflow), 32'(ovf));
        chk({tag, ".unf"}, 32'(Underflow), 32'(unf));
        chk({tag, ".err"}, 32'(Error), 32'(err));
    endtask

    logic [2:0] gray_seq [8];

    initial begin
        gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        Reset = 1'b1; En = 1'b0; GrayIn = '0;

        // Reset state
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b1, 1'b0, 3'b000);
        chk_flags("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.dir", 32'(Dir), 32'd0);
        chk("reset.cnt", 32'(ErrCount), 32'd0);

        // Full up-count 0..7; first sample is the reference
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, gray_seq[i]);
            chk_flags($sformatf("up%0d", i), 3'(i), 1'b1, (i != 0), 1'b0, 1'b0, 1'b0);
            chk($sformatf("up%0d.dir", i), 32'(Dir), (i != 0) ? 32'd1 : 32'd0);
        end

        // No strobe: no Valid, Binary holds
        cyc(1'b0, 1'b0, 3'b011);
        chk_flags("idle", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap up 7 -> 0, pulse lasts one cycle
        cyc(1'b0, 1'b1, 3'b000);
        chk_flags("wrap_up", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_up.dir", 32'(Dir), 32'd1);
        cyc(1'b0, 1'b0, 3'b000);
        chk_flags("wrap_up_end", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap down 0 -> 7
        cyc(1'b0, 1'b1, 3'b100);
        chk_flags("wrap_dn", 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_dn.dir", 32'(Dir), 32'd0);

        // Back up to 0, then hold keeps Dir
        cyc(1'b0, 1'b1, 3'b000);
        chk_flags("wrap_up2", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b000);
        chk_flags("hold", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold.dir", 32'(Dir), 32'd1);

        // Illegal jump 0 -> 3 enters FAULT
        cyc(1'b0, 1'b1, 3'b010);
        chk_flags("illegal", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("illegal.cnt", 32'(ErrCount), exp_cnt(1));

        // Two legal samples resynchronise
        cyc(1'b0, 1'b1, 3'b110);
        chk_flags("resync1", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 3'b111);
        chk_flags("resync2", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b101);
        chk_flags("tracked", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tracked.dir", 32'(Dir), 32'd1);

        // Fault, then an illegal sample inside FAULT
        cyc(1'b0, 1'b1, 3'b000);
        chk_flags("fault2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fault2.cnt", 32'(ErrCount), exp_cnt(2));
        cyc(1'b0, 1'b1, 3'b011);
        chk_flags("fault3", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fault3.cnt", 32'(ErrCount), exp_cnt(3));

        // One legal sample is not enough to leave FAULT
        cyc(1'b0, 1'b1, 3'b010);
        chk_flags("partial", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset with En high while in FAULT
        cyc(1'b1, 1'b1, 3'b011);
        chk_flags("rst_fault", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_fault.cnt", 32'(ErrCount), 32'd0);

        // First sample after reset is a reference, even if far from 0
        cyc(1'b0, 1'b1, 3'b011);
        chk_flags("ref", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'b010);
        chk_flags("ref_up", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // 300 illegal samples alternating 0 / 2
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, (i % 2 == 0) ? 3'b000 : 3'b011);
            if (i == 9)
                chk("sat10.cnt", 32'(ErrCount), exp_cnt(10));
            if (i == 254)
                chk("sat255.cnt", 32'(ErrCount), exp_cnt(255));
        end
        chk("sat.cnt", 32'(ErrCount), exp_cnt(300));
        chk("sat.err", 32'(Error), 32'd1);

        cyc(1'b1, 1'b0, 3'b000);
        chk("final_rst.cnt", 32'(ErrCount), 32'd0);
        chk("final_rst.err", 32'(Error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the Gray-coded position/count bus produced by our Gray counters.
- Samples a WIDTH-bit Gray word when En is high and decodes it to binary. Classifies each step against the previous sample as up, down, hold or illegal.
- Flags wrap-around and faults, and resynchronises after a fault.
- Sits between any Gray-count source (counters, encoders, CDC pointers) and binary consumers.

Parameters:
- WIDTH, 3, width of the Gray input and binary output.
- RESYNC, 2, consecutive legal samples required to leave FAULT (1..15).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample strobe; GrayIn is captured on Clk when En=1.
- GrayIn  input  WIDTH  Gray-coded input word.
- Binary  output  WIDTH  decoded value of the last accepted sample.
- Valid  output  1  one-cycle pulse: Binary/Dir/Step updated this cycle.
- Step  output  1  with Valid: sample differed from previous by exactly ±1.
- Dir  output  1  with Step: 1 = up (+1 mod 2^WIDTH), 0 = down.
- Overflow  output  1  with Valid: up-step from 2^WIDTH-1 to 0.
- Underflow  output  1  with Valid: down-step from 0 to 2^WIDTH-1.
- Error  output  1  level: high while the state is FAULT.
- ErrCount  output  8  count of illegal transitions (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, previous-value register 0, resync counter 0.
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. This is purely combinational on GrayIn.
- Latency: En high at edge N → Valid, Binary and flags valid after edge N (one register stage). Valid is never high without a preceding En.
- diff = (new − prev) mod 2^WIDTH. Legal means diff ∈ {0, 1, 2^WIDTH−1}.
- Hold (diff=0): Valid=1, Step=0; Dir keeps its last value.
- States:
  - IDLE: the first En captures a reference. Valid=1, Step=0, no error check. Go to TRACK.
  - TRACK: on each En, classify the sample.
    - Legal: set Step/Dir/Overflow/Underflow as above.
    - Illegal: Valid=1, Step=0, Binary=new value. Go to FAULT, resync counter=0, increment ErrCount.
  - FAULT: Error=1. On each En, Valid=1, Binary updates, Step/Overflow/Underflow forced 0.
    - Legal sample: resync counter+1. When it reaches RESYNC, go to TRACK on that edge; Error drops the next cycle.
    - Illegal sample: resync counter=0 and ErrCount increments.
- prev is updated on every accepted sample in all states, including illegal ones.
- Overflow and Underflow are one-cycle pulses and are mutually exclusive.
- Reset asserted together with En: Reset wins, no Valid.
- Reset mid-FAULT: returns to IDLE, Error=0, ErrCount=0.
- WIDTH=1: every change is ±1, so FAULT is unreachable.

Optional Feature:
- Macro GRAY_ERRCNT_EN.
- Defined: ErrCount is an 8-bit saturating counter of illegal transitions. It holds at 255 and clears only on Reset.
- Undefined: the ErrCount port remains but is tied to 0 and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared package gray_pkg:
  - State encodings ST_IDLE=2'd0, ST_TRACK=2'd1, ST_FAULT=2'd2.
  - Default GRAY_WIDTH=3.
  - ERRCNT_W=8.
- One combinational sub-module gray_to_bin (parameter WIDTH, XOR prefix chain). gray_decoder instantiates it; other Gray consumers reuse it.

Test Plan (WIDTH=3, RESYNC=2):
- Reset, then En with Gray 000,001,011,010,110,111,101,100 → Binary 0..7, each Valid. First sample Step=0; the rest Step=1, Dir=1. Error stays 0.
- Continue from 100 to 000 → Binary=0, Step=1, Dir=1, Overflow=1 for one cycle. Then 000→100 → Binary=7, Dir=0, Underflow=1.
- From 000 apply 010 (binary 3) → Valid=1, Step=0, Binary=3, Error=1 next cycle, ErrCount=1.
- In FAULT apply 110 (4) → counter 1, Error still 1. Then 111 (5) → TRACK, Error=0. Then 101 (6) → Step=1, Dir=1.
- Assert Reset while in FAULT with En high and GrayIn=011 → no Valid; Binary=0, Error=0, ErrCount=0. The next En is treated as an IDLE reference with Step=0.
- With GRAY_ERRCNT_EN defined, apply 300 alternating 000/011 samples → ErrCount saturates at 255. Undefined build → ErrCount=0 throughout.
